wb_walk_requester: RTL and testbench

- Single-transaction Wishbone (classic-pipelined) bus master that feeds the LED-walker slave directly downstream of it.
- Converts a trigger pulse plus a 6-bit pattern into one write cycle, and honours slave stall.
- Waits for ack, with timeout protection.
- Buffers one further request that arrives while busy.

---
 rtl/wb_walk_pkg.sv | 14 +
 rtl/wb_walk_requester_if.sv | 25 ++
 rtl/wb_walk_timer.sv | 42 ++++
 rtl/wb_walk_requester.sv | 183 ++++++++++++++++++
 tb/tb_wb_walk_requester.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_walk_pkg.sv
// Shared definitions for the LED-walker Wishbone requester: FSM state
// encoding, default data width and the fixed slave address.
package wb_walk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } walk_state_e;

  localparam int   DW_DEF    = 6;
  localparam logic WALK_ADDR = 1'b0;

endpackage

// File: rtl/wb_walk_requester_if.sv
// Wishbone classic-pipelined link between the walk requester (master)
// and the LED-walker slave.
interface wb_walk_requester_if #(
  parameter int DW = wb_walk_pkg::DW_DEF
) ();

  logic          o_cyc;
  logic          o_stb;
  logic          o_we;
  logic          o_addr;
  logic [DW-1:0] o_data;
  logic          i_stall;
  logic          i_ack;

  modport master (
    output o_cyc, o_stb, o_we, o_addr, o_data,
    input  i_stall, i_ack
  );

  modport slave (
    input  o_cyc, o_stb, o_we, o_addr, o_data,
    output i_stall, i_ack
  );

endinterface

// File: rtl/wb_walk_timer.sv
// Generic counter with synchronous clear. At TERMINAL it either holds
// (saturating, PERIODIC=0) or wraps to zero (PERIODIC=1). o_tc is high
// while the count equals TERMINAL.
module wb_walk_timer #(
  parameter int W        = 6,
  parameter int TERMINAL = 30,
  parameter bit PERIODIC = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, then advance, hold or wrap at the terminal value.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      if (count_q == TC_VAL) begin
        count_d = PERIODIC ? '0 : count_q;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) count_q <= '0;
    else            count_q <= count_d;
  end

  assign o_tc = (count_q == TC_VAL);

endmodule

// File: rtl/wb_walk_requester.sv
// Single-transaction Wishbone write master for the LED walker. A trigger
// pulse issues one write of i_pattern; one further request is buffered
// while busy; ack is awaited with timeout protection.
// Optional: define WB_WALK_AUTO_TRIGGER_EN to add an internal trigger
// every PERIOD clocks.
module wb_walk_requester
  import wb_walk_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 31,
  parameter int PERIOD  = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_trigger,
  input  logic [DW-1:0]        i_pattern,
  wb_walk_requester_if.master  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  walk_state_e   state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic          done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] data_q, data_d, pdata_q, pdata_d;
  logic          trig, to_tc, acked, abort;

`ifdef WB_WALK_AUTO_TRIGGER_EN
  logic auto_tc;

  wb_walk_timer #(
    .W        ($clog2(PERIOD) + 1),
    .TERMINAL (PERIOD - 1),
    .PERIODIC (1'b1)
  ) u_auto (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (1'b0),
    .i_en      (1'b1),
    .o_tc      (auto_tc)
  );

  assign trig = i_trigger | auto_tc;
`else
  assign trig = i_trigger;
`endif

  // The timeout count runs only while a cycle is on the bus and is held at
  // zero otherwise, so it always starts from 0 when o_cyc rises.
  wb_walk_timer #(
    .W        (TW),
    .TERMINAL (TIMEOUT - 1),
    .PERIODIC (1'b0)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (!cyc_q),
    .i_en      (cyc_q),
    .o_tc      (to_tc)
  );

  // Next-state and registered-output logic for the write transaction.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
    acked   = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q || trig) begin
          data_d  = pend_q ? pdata_q : i_pattern;
          pend_d  = 1'b0;
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        if (!cyc_q) begin
          // One-cycle gap after a back-to-back completion: relaunch now.
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          err_d = 1'b0;
        end else if (!bus.i_stall && bus.i_ack) begin
          acked = 1'b1;
        end else if (to_tc) begin
          abort = 1'b1;
        end else if (!bus.i_stall) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_ack)  acked = 1'b1;
        else if (to_tc) abort = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (acked) begin
      done_d = 1'b1;
      cyc_d  = 1'b0;
      stb_d  = 1'b0;
      we_d   = 1'b0;
      if (pend_q) begin
        state_d = REQ;
        data_d  = pdata_q;
        pend_d  = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end

    if (abort) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b1;
      state_d = IDLE;
    end

    // Depth-one buffer: the first request seen while busy is kept.
    if (trig && (state_q != IDLE) && !pend_q) begin
      pend_d  = 1'b1;
      pdata_d = i_pattern;
    end

    busy_d = (state_d != IDLE) || pend_d;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
    end
  end

  assign bus.o_cyc  = cyc_q;
  assign bus.o_stb  = stb_q;
  assign bus.o_we   = we_q;
  assign bus.o_addr = WALK_ADDR;
  assign bus.o_data = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_wb_walk_requester.sv
// Testbench for wb_walk_requester: directed scenarios and randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_wb_walk_requester;

  localparam int DW      = 6;
  localparam int TIMEOUT = 31;
  localparam int PERIOD  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          stall = 1'b0;
  logic          ack = 1'b0;
  logic [DW-1:0] pat = '0;
  logic          busy, done, err;

  wb_walk_requester_if #(.DW(DW)) bus ();
  assign bus.i_stall = stall;
  assign bus.i_ack   = ack;

  wb_walk_requester #(.DW(DW), .TIMEOUT(TIMEOUT), .PERIOD(PERIOD)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_trigger (trig),
    .i_pattern (pat),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is "on the bus" from launch to its end;
  // a back-to-back successor waits one dead cycle before launching.
  bit        m_on_bus, m_strobing, m_gap_next;
  bit        m_cyc, m_stb, m_done, m_err, m_pend;
  int        m_age, m_data, m_pval, m_auto;

  function automatic void m_launch(input int v);
    m_data = v; m_on_bus = 1; m_strobing = 1; m_age = 0;
    m_cyc = 1; m_stb = 1; m_err = 0;
  endfunction

  function automatic void m_end_bus();
    m_on_bus = 0; m_strobing = 0; m_cyc = 0; m_stb = 0;
  endfunction

  function automatic void model(input bit t, input int p, input bit s,
                                input bit a, input bit r);
    bit busy_before, gap_now, done_now, req;
    if (!r) begin
      m_on_bus = 0; m_strobing = 0; m_gap_next = 0; m_cyc = 0; m_stb = 0;
      m_done = 0; m_err = 0; m_pend = 0; m_age = 0; m_data = 0; m_pval = 0;
      m_auto = 0;
      return;
    end
    req = t;
`ifdef WB_WALK_AUTO_TRIGGER_EN
    if (m_auto == PERIOD - 1) begin req = 1; m_auto = 0; end
    else m_auto++;
`endif
    busy_before = m_on_bus || m_gap_next;
    gap_now     = m_gap_next;
    m_gap_next  = 0;
    done_now    = 0;
    if (gap_now) begin
      m_launch(m_data);
    end else if (m_on_bus) begin
      if (a && (!m_strobing || !s)) begin
        done_now = 1;
        m_end_bus();
        if (m_pend) begin m_data = m_pval; m_pend = 0; m_gap_next = 1; end
      end else if (m_age == TIMEOUT - 1) begin
        m_end_bus();
        m_err = 1;
      end else begin
        m_age++;
        if (m_strobing && !s) begin m_strobing = 0; m_stb = 0; end
      end
    end else if (m_pend) begin
      m_launch(m_pval);
      m_pend = 0;
    end else if (req) begin
      m_launch(p);
    end
    if (req && busy_before && !(m_pend && !done_now && !gap_now) &&
        !(done_now && m_gap_next)) begin
      m_pend = 1; m_pval = p;
    end
    m_done = done_now;
  endfunction

  // Per-scenario statistics gathered from the DUT outputs.
  int n_stb, n_cyc, n_done;
  int rises[$];
  bit prev_stb;

  task automatic clear_stats();
    n_stb = 0; n_cyc = 0; n_done = 0; rises.delete();
  endtask

  task automatic step(input bit t, input logic [DW-1:0] p, input bit s,
                      input bit a, input bit r);
    trig = t; pat = p; stall = s; ack = a; rst_n = r;
    @(posedge clk);
    model(t, int'(p), s, a, r);
    #1;
    chk("cyc",  int'(bus.o_cyc),  int'(m_cyc));
    chk("stb",  int'(bus.o_stb),  int'(m_stb));
    chk("we",   int'(bus.o_we),   int'(m_stb));
    chk("addr", int'(bus.o_addr), 0);
    chk("data", int'(bus.o_data), m_data);
    chk("done", int'(done),       int'(m_done));
    chk("err",  int'(err),        int'(m_err));
    chk("busy", int'(busy),       int'(m_on_bus || m_gap_next || m_pend));
    n_stb  += int'(bus.o_stb);
    n_cyc  += int'(bus.o_cyc);
    n_done += int'(done);
    if (bus.o_stb && !prev_stb) rises.push_back(int'(bus.o_data));
    prev_stb = bus.o_stb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
  endtask

  initial begin
    bit ack_on;
    do_reset();
    chk("reset_cyc", int'(bus.o_cyc), 0);
    chk("reset_busy", int'(busy), 0);

`ifndef WB_WALK_AUTO_TRIGGER_EN
    // Single write, ack one cycle after accept.
    clear_stats();
    step(1, 6'h2A, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    idle(3);
    chk("single_stb_cycles", n_stb, 1);
    chk("single_cyc_cycles", n_cyc, 2);
    chk("single_done", n_done, 1);
    chk("single_data", rises.size() > 0 ? rises[0] : -1, 'h2A);
    chk("single_err", int'(err), 0);

    // Stall for 11 cycles after the strobe rises.
    clear_stats();
    step(1, 6'h15, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(0, 6'h3F, 1, 1, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    idle(2);
    chk("stall_stb_cycles", n_stb, 12);
    chk("stall_rises", rises.size(), 1);
    chk("stall_done", n_done, 1);
    chk("stall_err", int'(err), 0);

    // Back-to-back through the pending buffer; third request dropped.
    clear_stats();
    step(1, 6'h01, 0, 0, 1);
    step(1, 6'h05, 0, 0, 1);
    step(1, 6'h07, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 0, 1);
    chk("b2b_gap_cyc", int'(bus.o_cyc), 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    idle(4);
    chk("b2b_done", n_done, 2);
    chk("b2b_rises", rises.size(), 2);
    chk("b2b_second", rises.size() > 1 ? rises[1] : -1, 'h05);

    // Timeout: no ack ever.
    clear_stats();
    step(1, 6'h22, 0, 0, 1);
    for (int i = 0; i < 39; i++) step(0, '0, 0, 0, 1);
    chk("to_cyc_cycles", n_cyc, TIMEOUT);
    chk("to_err", int'(err), 1);
    step(1, 6'h11, 0, 0, 1);
    chk("to_err_cleared", int'(err), 0);
    step(0, '0, 0, 1, 1);
    idle(2);

    // Reset while waiting for ack with a request pending.
    step(1, 6'h0C, 0, 0, 1);
    step(1, 6'h09, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    chk("rst_cyc", int'(bus.o_cyc), 0);
    chk("rst_busy", int'(busy), 0);
    clear_stats();
    step(0, '0, 0, 1, 1);
    idle(5);
    chk("rst_late_done", n_done, 0);
    chk("rst_no_pending", rises.size(), 0);
`else
    // Free-running auto trigger with immediate ack.
    do_reset();
    clear_stats();
    for (int i = 0; i < 5 * PERIOD; i++) step(0, 6'h2B, 0, 1, 1);
    chk("auto_rises", rises.size(), 5);
    chk("auto_done", n_done, 4);
`endif

    // Randomized traffic; some blocks never ack to force timeouts.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ack_on = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 7) == 0, 6'($urandom_range(0, 63)),
           $urandom_range(0, 2) == 0,
           ack_on && ($urandom_range(0, 2) == 0),
           $urandom_range(0, 599) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
